capture_arbiter: RTL and testbench

- Shares one capture buffer (dual-port line RAM, capture-on-request, read-out-in-burst) among NUM_REQ requesters.
- Round-robin grant; drives the buffer's Request and point count; times the Request hold so the buffer's write-clock sampler catches it.
- Monitors data_vaild/data_tlast, steers the read burst to the granted requester, and reports done, timeout and length errors.
- Sits in the rd_clk domain between the requester blocks and the buffer.

---
 rtl/capture_arbiter.sv | 178 +++++++++++++++++
 tb/tb_capture_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_arbiter.sv
// Round-robin arbiter sharing one capture buffer among NUM_REQ requesters in the rd_clk domain.
// Issues a timed buffer Request, steers the read burst to the owner and reports done/timeout/length errors.
module capture_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int REQ_HOLD   = 16,
    parameter int TIMEOUT    = 65536,
    parameter int MAX_POINTS = 2047,
    parameter int DATA_WIDTH = 12
) (
    input  logic                    rd_clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [32*NUM_REQ-1:0]   req_points,
    output logic                    buf_request,
    output logic [31:0]             buf_points,
    input  logic [DATA_WIDTH-1:0]   buf_rd_data,
    input  logic                    buf_valid,
    input  logic                    buf_last,
    output logic [NUM_REQ-1:0]      gnt,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_valid,
    output logic                    out_last,
    output logic [NUM_REQ-1:0]      done,
    output logic [NUM_REQ-1:0]      err,
    output logic [1:0]              err_code,
    output logic                    busy
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FINISH} state_t;

    state_t                 state_q;
    logic [PW-1:0]          rrPtr_q;
    logic [PW-1:0]          grantIdx_q;
    logic [NUM_REQ-1:0]     gnt_q;
    logic [NUM_REQ-1:0]     done_q;
    logic [NUM_REQ-1:0]     err_q;
    logic [1:0]             errCode_q;
    logic                   bufRequest_q;
    logic [31:0]            bufPoints_q;
    logic [31:0]            holdCnt_q;
    logic [31:0]            toCnt_q;
    logic [31:0]            beatCnt_q;
    logic [DATA_WIDTH-1:0]  outData_q;
    logic                   outValid_q;
    logic                   outLast_q;

    logic                   winFound;
    logic [PW-1:0]          winIdx;
    logic [PW-1:0]          candIdx;
    logic [NUM_REQ-1:0]     winOneHot;
    logic [31:0]            winPoints;
    logic [31:0]            beatCnt_d;
    logic                   pointsBad;
    logic                   timedOut;
    logic                   lenMatch;
    logic                   inWait;

    // First pending requester strictly after the last owner, wrapping around.
    always_comb begin
        winFound = 1'b0;
        winIdx   = '0;
        candIdx  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            candIdx = PW'((int'(rrPtr_q) + k) % NUM_REQ);
            if (!winFound && req[candIdx]) begin
                winFound = 1'b1;
                winIdx   = candIdx;
            end
        end
    end

    always_comb begin
        winOneHot         = '0;
        winOneHot[winIdx] = 1'b1;
    end

    assign winPoints = req_points[{winIdx, 5'b00000} +: 32];
    assign pointsBad = (winPoints == 32'd0) || (winPoints > 32'(MAX_POINTS));
    assign beatCnt_d = beatCnt_q + {31'd0, buf_valid};
    assign lenMatch  = (beatCnt_d == bufPoints_q);
    assign timedOut  = (toCnt_q >= 32'(TIMEOUT - 1));
    assign inWait    = (state_q == WAIT);

    // Burst data is only forwarded while WAIT owns the buffer; anything else is stray.
    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rrPtr_q      <= PW'(NUM_REQ - 1);
            grantIdx_q   <= '0;
            gnt_q        <= '0;
            done_q       <= '0;
            err_q        <= '0;
            errCode_q    <= 2'd0;
            bufRequest_q <= 1'b0;
            bufPoints_q  <= '0;
            holdCnt_q    <= '0;
            toCnt_q      <= '0;
            beatCnt_q    <= '0;
            outData_q    <= '0;
            outValid_q   <= 1'b0;
            outLast_q    <= 1'b0;
        end else begin
            done_q     <= '0;
            err_q      <= '0;
            errCode_q  <= 2'd0;
            outValid_q <= buf_valid & inWait;
            outLast_q  <= buf_last & inWait;
            outData_q  <= inWait ? buf_rd_data : '0;
            case (state_q)
                IDLE: begin
                    gnt_q <= '0;
                    if (winFound) begin
                        gnt_q       <= winOneHot;
                        grantIdx_q  <= winIdx;
                        bufPoints_q <= winPoints;
                        if (pointsBad) begin
                            err_q     <= winOneHot;
                            errCode_q <= 2'd1;
                            rrPtr_q   <= winIdx;
                        end else begin
                            state_q      <= ISSUE;
                            bufRequest_q <= 1'b1;
                            holdCnt_q    <= '0;
                            toCnt_q      <= '0;
                        end
                    end
                end
                ISSUE: begin
                    holdCnt_q <= holdCnt_q + 32'd1;
                    toCnt_q   <= toCnt_q + 32'd1;
                    if (holdCnt_q == 32'(REQ_HOLD - 1)) begin
                        bufRequest_q <= 1'b0;
                        beatCnt_q    <= '0;
                        state_q      <= WAIT;
                    end
                end
                WAIT: begin
                    toCnt_q   <= toCnt_q + 32'd1;
                    beatCnt_q <= beatCnt_d;
                    // A last beat landing on the timeout cycle still completes the burst.
                    if (buf_last) begin
                        state_q <= FINISH;
                        if (lenMatch) begin
                            done_q <= gnt_q;
                        end else begin
                            err_q     <= gnt_q;
                            errCode_q <= 2'd3;
                        end
                    end else if (timedOut) begin
                        state_q   <= FINISH;
                        err_q     <= gnt_q;
                        errCode_q <= 2'd2;
                    end
                end
                FINISH: begin
                    rrPtr_q <= grantIdx_q;
                    gnt_q   <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign buf_request = bufRequest_q;
    assign buf_points  = bufPoints_q;
    assign gnt         = gnt_q;
    assign done        = done_q;
    assign err         = err_q;
    assign err_code    = errCode_q;
    assign out_data    = outData_q;
    assign out_valid   = outValid_q;
    assign out_last    = outLast_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_capture_arbiter.sv
// Randomized self-checking bench for capture_arbiter with a transaction-level round-robin model
// and a small buffer responder driving bursts, gaps, mismatches, timeouts and resets.
module tb_capture_arbiter;

    localparam int NREQ = 4;
    localparam int HOLD = 16;
    localparam int TO   = 100;
    localparam int MAXP = 2047;
    localparam int DW   = 12;

    logic               rd_clk = 1'b0;
    logic               rst_n;
    logic [NREQ-1:0]    req;
    logic [32*NREQ-1:0] req_points;
    logic               buf_request;
    logic [31:0]        buf_points;
    logic [DW-1:0]      buf_rd_data;
    logic               buf_valid;
    logic               buf_last;
    logic [NREQ-1:0]    gnt;
    logic [DW-1:0]      out_data;
    logic               out_valid;
    logic               out_last;
    logic [NREQ-1:0]    done;
    logic [NREQ-1:0]    err;
    logic [1:0]         err_code;
    logic               busy;

    int          passCnt = 0;
    int          checkCnt = 0;
    int          modelPtr = NREQ - 1;
    int          cyc = 0;
    logic [31:0] ptsTab [NREQ];

    capture_arbiter #(
        .NUM_REQ(NREQ), .REQ_HOLD(HOLD), .TIMEOUT(TO), .MAX_POINTS(MAXP), .DATA_WIDTH(DW)
    ) dut (
        .rd_clk(rd_clk), .rst_n(rst_n), .req(req), .req_points(req_points),
        .buf_request(buf_request), .buf_points(buf_points), .buf_rd_data(buf_rd_data),
        .buf_valid(buf_valid), .buf_last(buf_last), .gnt(gnt), .out_data(out_data),
        .out_valid(out_valid), .out_last(out_last), .done(done), .err(err),
        .err_code(err_code), .busy(busy)
    );

    always #5 rd_clk = ~rd_clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCnt++;
        if (observed === expected) passCnt++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    endtask

    task automatic step();
        @(posedge rd_clk);
        #1;
        cyc++;
    endtask

    function automatic int pickWinner(input logic [NREQ-1:0] mask);
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (modelPtr + k) % NREQ;
            if (mask[idx]) return idx;
        end
        return 0;
    endfunction

    // scenario: 0 last with final beat, 1 last on its own cycle, 2 never last, 3 last on the timeout cycle
    task automatic applyStimulus(input logic [NREQ-1:0] mask, input int scenario, input int nBeats, input bit dropReq);
        int            w;
        int            hold;
        int            sent;
        int            guard;
        bit            fin;
        bit            v;
        bit            l;
        logic [31:0]   p;
        logic [NREQ-1:0] oh;
        logic [DW-1:0] data;
        w  = pickWinner(mask);
        p  = ptsTab[w];
        oh = NREQ'(1) << w;
        req = mask;
        for (int i = 0; i < NREQ; i++) req_points[32*i +: 32] = ptsTab[i];
        buf_valid = 1'b0;
        buf_last  = 1'b0;
        step();
        cyc = 0;
        modelPtr = w;
        checkOutput("gnt", gnt, oh);
        checkOutput("buf_points", buf_points, p);
        if (p == 0 || p > MAXP) begin
            checkOutput("bad_err", err, oh);
            checkOutput("bad_code", err_code, 2'd1);
            checkOutput("bad_no_request", buf_request, 1'b0);
            req = '0;
            step();
            checkOutput("bad_gnt_clear", gnt, '0);
            checkOutput("bad_err_once", err, '0);
            checkOutput("bad_no_request2", buf_request, 1'b0);
            return;
        end
        checkOutput("busy_issue", busy, 1'b1);
        if (dropReq) req = '0;
        for (int i = 0; i < NREQ; i++) req_points[32*i +: 32] = $urandom;
        hold = 0;
        while (buf_request === 1'b1 && hold < 64) begin
            hold++;
            step();
        end
        checkOutput("hold_len", hold, HOLD);
        sent  = 0;
        guard = 0;
        fin   = 1'b0;
        while (!fin && guard < 200) begin
            v = 1'b0;
            l = 1'b0;
            if (scenario == 3) begin
                if (sent < nBeats) v = 1'b1;
                else if (cyc == TO - 1) l = 1'b1;
            end else if (scenario == 2) begin
                v = (sent < nBeats) && ($urandom_range(0, 1) == 1);
            end else if (sent < nBeats) begin
                v = ($urandom_range(0, 3) != 0) || (cyc > 60);
                l = v && (scenario == 0) && (sent == nBeats - 1);
            end else begin
                l = 1'b1;
            end
            data        = DW'($urandom);
            buf_valid   = v;
            buf_last    = l;
            buf_rd_data = data;
            if (v) sent++;
            step();
            guard++;
            buf_valid = 1'b0;
            buf_last  = 1'b0;
            fin = l || (scenario == 2 && cyc >= TO);
            checkOutput("out_valid", out_valid, v);
            checkOutput("out_last", out_last, l);
            if (v) checkOutput("out_data", out_data, data);
            if (!fin) checkOutput("no_early_end", {done, err}, '0);
        end
        if (scenario == 2) begin
            checkOutput("timeout_cycle", cyc, TO);
            checkOutput("timeout_err", {done, err}, {{NREQ{1'b0}}, oh});
            checkOutput("timeout_code", err_code, 2'd2);
        end else if (sent == p) begin
            checkOutput("done_pulse", {done, err}, {oh, {NREQ{1'b0}}});
        end else begin
            checkOutput("len_err", {done, err}, {{NREQ{1'b0}}, oh});
            checkOutput("len_code", err_code, 2'd3);
        end
        checkOutput("points_stable", buf_points, p);
        checkOutput("gnt_finish", gnt, oh);
        step();
        checkOutput("idle_after", {gnt, done, err, busy, buf_request}, '0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [NREQ-1:0] mask;
        int              w;
        int              sc;
        int              nb;
        rst_n       = 1'b0;
        req         = '0;
        req_points  = '0;
        buf_rd_data = '0;
        buf_valid   = 1'b0;
        buf_last    = 1'b0;
        repeat (3) @(posedge rd_clk);
        #1;
        checkOutput("reset_outputs", {gnt, buf_request, buf_points, out_valid, out_last, out_data, done, err, err_code, busy}, '0);
        #3 rst_n = 1'b1;
        step();
        checkOutput("idle_after_reset", {gnt, busy, buf_request}, '0);

        $display("[TB] single requester");
        ptsTab = '{32'd8, 32'd4, 32'd4, 32'd4};
        applyStimulus(4'b0001, 0, 8, 1'b0);

        $display("[TB] round robin");
        ptsTab = '{32'd4, 32'd4, 32'd4, 32'd4};
        for (int t = 0; t < 6; t++) applyStimulus(4'b1011, 0, 4, 1'b0);

        $display("[TB] bad counts and largest legal count");
        ptsTab = '{32'd4, 32'd4, 32'd0, 32'd4};
        applyStimulus(4'b0100, 0, 4, 1'b0);
        ptsTab[2] = 32'd2048;
        applyStimulus(4'b0100, 0, 4, 1'b0);
        ptsTab[2] = 32'd2047;
        applyStimulus(4'b0100, 2, 3, 1'b1);

        $display("[TB] timeout, mismatch, collision");
        ptsTab = '{32'd8, 32'd4, 32'd4, 32'd4};
        applyStimulus(4'b0001, 2, 2, 1'b1);
        applyStimulus(4'b0001, 0, 8, 1'b0);
        applyStimulus(4'b0001, 1, 7, 1'b0);
        applyStimulus(4'b0001, 3, 8, 1'b0);

        $display("[TB] randomized traffic");
        for (int t = 0; t < 40; t++) begin
            mask = NREQ'($urandom_range(1, 15));
            for (int i = 0; i < NREQ; i++) begin
                case ($urandom_range(0, 9))
                    0:       ptsTab[i] = 32'd0;
                    1:       ptsTab[i] = 32'd2048 + 32'($urandom_range(0, 100));
                    default: ptsTab[i] = 32'($urandom_range(1, 12));
                endcase
            end
            w  = pickWinner(mask);
            sc = $urandom_range(0, 19);
            sc = (sc < 10) ? 0 : (sc < 14) ? 1 : (sc < 17) ? 2 : 3;
            if (sc == 2) nb = $urandom_range(0, 5);
            else if (sc == 3) nb = int'(ptsTab[w]);
            else nb = int'(ptsTab[w]) + $urandom_range(0, 2) - 1;
            if (nb < 0) nb = 0;
            applyStimulus(mask, sc, nb, 1'($urandom_range(0, 1)));
        end

        $display("[TB] reset during burst");
        ptsTab = '{32'd8, 32'd5, 32'd5, 32'd5};
        req = 4'b0001;
        for (int i = 0; i < NREQ; i++) req_points[32*i +: 32] = ptsTab[i];
        step();
        checkOutput("rst_test_gnt", gnt, 4'b0001);
        repeat (HOLD) step();
        for (int b = 0; b < 3; b++) begin
            buf_valid   = 1'b1;
            buf_rd_data = DW'($urandom);
            step();
        end
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_outputs", {gnt, buf_request, buf_points, out_valid, out_last, out_data, done, err, err_code, busy}, '0);
        req       = '0;
        buf_last  = 1'b1;
        repeat (2) step();
        #3 rst_n = 1'b1;
        modelPtr = NREQ - 1;
        for (int s = 0; s < 4; s++) begin
            buf_valid = 1'($urandom_range(0, 1));
            buf_last  = 1'($urandom_range(0, 1));
            step();
            checkOutput("stray_ignored", {gnt, busy, out_valid, out_last, done, err}, '0);
        end
        buf_valid = 1'b0;
        buf_last  = 1'b0;
        applyStimulus(4'b1111, 0, 5, 1'b0);

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
